// File: rtl/sid_filter_sequencer_pkg.sv
// Shared types for the SID filter sequencer: filter state vector, sample type, stage count and
// sequencer FSM encoding.
package sid_filter_sequencer_pkg;

  localparam int unsigned FILTER_STAGES = 8;

  typedef logic signed [23:0] s24_t;

  typedef struct packed {
    s24_t vlp;
    s24_t vbp;
    s24_t vhp;
  } filter_v_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StCapture
  } seq_state_t;

  // Saturate a 24-bit value into the 23-bit signed range [-2^22, 2^22-1].
  function automatic s24_t sat_s23(input s24_t v);
    if (v[23] != v[22]) begin
      return v[23] ? 24'shC00000 : 24'sh3FFFFF;
    end
    return v;
  endfunction

endpackage

// File: rtl/sid_filter_sequencer_if.sv
// Filter-side interface of the sequencer: stage/instance select, state out/in and filter audio.
interface sid_filter_sequencer_if #(
  parameter int unsigned SEL_W = 1
);
  import sid_filter_sequencer_pkg::*;

  logic [2:0]       stage_o;
  logic [SEL_W-1:0] sid_sel_o;
  filter_v_t        state_o;
  filter_v_t        state_i;
  s24_t             audio_i;

  modport master (
    output stage_o,
    output sid_sel_o,
    output state_o,
    input  state_i,
    input  audio_i
  );

  modport slave (
    input  stage_o,
    input  sid_sel_o,
    input  state_o,
    output state_i,
    output audio_i
  );
endinterface

// File: rtl/sid_filter_state_ram.sv
// Per-instance filter state register file: one registered read port, one write port.
// Optional write-back saturation under SID_FILTER_SEQUENCER_CLAMP_EN.
module sid_filter_state_ram
  import sid_filter_sequencer_pkg::*;
#(
  parameter int unsigned N_SIDS = 2,
  parameter int unsigned SEL_W  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] rd_addr_i,
  output filter_v_t        rd_data_o,
  input  logic             wr_en_i,
  input  logic [SEL_W-1:0] wr_addr_i,
  input  filter_v_t        wr_data_i,
  output logic             clamp_o
);

  filter_v_t mem_q [N_SIDS];
  filter_v_t rd_q;
  filter_v_t wr_val;

`ifdef SID_FILTER_SEQUENCER_CLAMP_EN
  logic sat_hit;
  logic clamp_q;

  always_comb begin
    wr_val.vlp = sat_s23(wr_data_i.vlp);
    wr_val.vbp = sat_s23(wr_data_i.vbp);
    wr_val.vhp = sat_s23(wr_data_i.vhp);
    sat_hit    = (wr_data_i.vlp[23] ^ wr_data_i.vlp[22]) |
                 (wr_data_i.vbp[23] ^ wr_data_i.vbp[22]) |
                 (wr_data_i.vhp[23] ^ wr_data_i.vhp[22]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clamp_q <= 1'b0;
    end else if (wr_en_i && sat_hit) begin
      clamp_q <= 1'b1;
    end
  end

  assign clamp_o = clamp_q;
`else
  assign wr_val  = wr_data_i;
  assign clamp_o = 1'b0;
`endif

  // Read and write in the same cycle on one entry return the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_SIDS); i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_addr_i] <= wr_val;
      end
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/sid_filter_sequencer.sv
// Steps the shared filter datapath through 8 stages per SID instance each tick, holding and
// writing back per-instance filter state and capturing each instance's audio sample.
// Optional feature macro: SID_FILTER_SEQUENCER_CLAMP_EN (write-back saturation, clamp_o).
module sid_filter_sequencer
  import sid_filter_sequencer_pkg::*;
#(
  parameter int unsigned N_SIDS = 2,
  parameter int unsigned SEL_W  = (N_SIDS > 1) ? $clog2(N_SIDS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_i,
  input  logic                   overrun_clr_i,
  sid_filter_sequencer_if.master flt,
  output logic [N_SIDS*24-1:0]   audio_o,
  output logic                   audio_valid_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   clamp_o
);

  seq_state_t       state_q, state_d;
  logic [2:0]       stage_q, stage_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             wr_en;
  logic             cap_q;
  logic [SEL_W-1:0] cap_sel_q;
  logic             valid_q;
  logic             overrun_q;
  s24_t             audio_q [N_SIDS];
  filter_v_t        rd_data;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    sel_d   = sel_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        stage_d = '0;
        sel_d   = '0;
        if (tick_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stage_q == 3'(FILTER_STAGES - 1)) begin
          wr_en   = 1'b1;
          stage_d = '0;
          if (sel_q == SEL_W'(N_SIDS - 1)) begin
            state_d = StCapture;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end else begin
          stage_d = stage_q + 3'd1;
        end
      end
      StCapture: begin
        state_d = StIdle;
        stage_d = '0;
        sel_d   = '0;
      end
      default: begin
        state_d = StIdle;
        stage_d = '0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      stage_q   <= '0;
      sel_q     <= '0;
      cap_q     <= 1'b0;
      cap_sel_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < int'(N_SIDS); i++) begin
        audio_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      sel_q     <= sel_d;
      // The filter registers its audio at the end of stage 7; grab it one cycle later.
      cap_q     <= wr_en;
      cap_sel_q <= sel_q;
      valid_q   <= (state_q == StCapture);
      if (cap_q) begin
        audio_q[cap_sel_q] <= flt.audio_i;
      end
      if (tick_i && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Read address is the next select so state_o is already valid in stage 0.
  sid_filter_state_ram #(
    .N_SIDS (N_SIDS),
    .SEL_W  (SEL_W)
  ) u_state_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_i (sel_d),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_addr_i (sel_q),
    .wr_data_i (flt.state_i),
    .clamp_o   (clamp_o)
  );

  always_comb begin
    audio_o = '0;
    for (int k = 0; k < int'(N_SIDS); k++) begin
      audio_o[24*k +: 24] = audio_q[k];
    end
  end

  assign flt.stage_o   = stage_q;
  assign flt.sid_sel_o = sel_q;
  assign flt.state_o   = rd_data;
  assign audio_valid_o = valid_q;
  assign busy_o        = (state_q != StIdle);
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_sid_filter_sequencer.sv
// Randomized self-checking bench for sid_filter_sequencer with a frame-level reference model.
module tb_sid_filter_sequencer;
  import sid_filter_sequencer_pkg::*;

  localparam int unsigned N_SIDS = 2;
  localparam int unsigned SEL_W  = 1;
  localparam int unsigned FRAME_LAT = N_SIDS * 8 + 2;
`ifdef SID_FILTER_SEQUENCER_CLAMP_EN
  localparam bit ClampEn = 1'b1;
`else
  localparam bit ClampEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_i = 1'b0;
  logic overrun_clr_i = 1'b0;
  logic [N_SIDS*24-1:0] audio_o;
  logic audio_valid_o, busy_o, overrun_o, clamp_o;

  always #5 clk = ~clk;

  sid_filter_sequencer_if #(.SEL_W(SEL_W)) flt ();

  sid_filter_sequencer #(
    .N_SIDS (N_SIDS),
    .SEL_W  (SEL_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick_i),
    .overrun_clr_i (overrun_clr_i),
    .flt           (flt),
    .audio_o       (audio_o),
    .audio_valid_o (audio_valid_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o),
    .clamp_o       (clamp_o)
  );

  // Filter stand-in: adds a per-instance delta to the presented state, registers audio at stage 7.
  int   dl [N_SIDS][3];
  s24_t aud_val [N_SIDS];
  bit   big_vlp = 1'b0;
  s24_t aud_reg = '0;

  always_comb begin
    flt.state_i.vlp = flt.state_o.vlp + s24_t'(dl[flt.sid_sel_o][0]);
    flt.state_i.vbp = flt.state_o.vbp + s24_t'(dl[flt.sid_sel_o][1]);
    flt.state_i.vhp = flt.state_o.vhp + s24_t'(dl[flt.sid_sel_o][2]);
    if (big_vlp) flt.state_i.vlp = 24'sh7FFFFF;
  end

  assign flt.audio_i = aud_reg;

  always @(posedge clk) begin
    if (busy_o && flt.stage_o == 3'd7) aud_reg <= aud_val[flt.sid_sel_o];
  end

  // Reference model: per-instance stored state, captured audio and sticky flags.
  s24_t ent [N_SIDS][3];
  s24_t aud_exp [N_SIDS];
  bit   clamp_exp = 1'b0;
  bit   ovr_exp = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic filter_v_t model_entry(input int k);
    filter_v_t v;
    v.vlp = ent[k][0];
    v.vbp = ent[k][1];
    v.vhp = ent[k][2];
    return v;
  endfunction

  function automatic logic [N_SIDS*24-1:0] model_audio();
    logic [N_SIDS*24-1:0] a;
    for (int k = 0; k < int'(N_SIDS); k++) a[24*k +: 24] = aud_exp[k];
    return a;
  endfunction

  function automatic s24_t model_store(input s24_t w);
    int iv;
    iv = int'(w);
    if (ClampEn && (iv > 4194303 || iv < -4194304)) begin
      clamp_exp = 1'b1;
      iv = (iv > 0) ? 4194303 : -4194304;
    end
    return s24_t'(iv);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < int'(N_SIDS); k++) begin
      aud_exp[k] = '0;
      for (int j = 0; j < 3; j++) ent[k][j] = '0;
    end
    clamp_exp = 1'b0;
    ovr_exp = 1'b0;
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge of the audio_valid_o cycle.
  task automatic do_frame(input bit fixed, input bit mid_tick, input bit mid_clr, input bit big);
    int n;
    int st;
    int sl;
    s24_t w;
    for (int k = 0; k < int'(N_SIDS); k++) begin
      for (int j = 0; j < 3; j++) dl[k][j] = fixed ? (j + 1) : int'($urandom_range(0, 255));
      aud_val[k] = fixed ? s24_t'(24'h000100 * (k + 1)) : s24_t'($urandom());
    end
    big_vlp = big;
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    n = 1;
    while (!audio_valid_o && n < 4 * int'(FRAME_LAT)) begin
      if (n <= int'(N_SIDS) * 8) begin
        st = (n - 1) % 8;
        sl = (n - 1) / 8;
        check("stage", 128'(flt.stage_o), 128'(st));
        check("sel", 128'(flt.sid_sel_o), 128'(sl));
        if (st == 0) check("state_rd", 128'(flt.state_o), 128'(model_entry(sl)));
      end
      check("busy", 128'(busy_o), 128'(1));
      if (mid_tick && n == 5) begin
        tick_i = 1'b1;
        overrun_clr_i = mid_clr;
      end else begin
        tick_i = 1'b0;
        overrun_clr_i = 1'b0;
      end
      if (mid_tick && n == 6) check("overrun_set", 128'(overrun_o), 128'(1));
      @(negedge clk);
      n++;
    end
    tick_i = 1'b0;
    overrun_clr_i = 1'b0;
    if (mid_tick) ovr_exp = 1'b1;
    check("latency", 128'(n), 128'(FRAME_LAT));
    check("busy_end", 128'(busy_o), 128'(0));
    for (int k = 0; k < int'(N_SIDS); k++) begin
      for (int j = 0; j < 3; j++) begin
        w = ent[k][j] + s24_t'(dl[k][j]);
        if (big && j == 0) w = 24'sh7FFFFF;
        ent[k][j] = model_store(w);
      end
      aud_exp[k] = aud_val[k];
    end
    check("audio", 128'(audio_o), 128'(model_audio()));
    check("overrun", 128'(overrun_o), 128'(ovr_exp));
    check("clamp", 128'(clamp_o), 128'(clamp_exp));
  endtask

  task automatic clear_overrun();
    overrun_clr_i = 1'b1;
    @(negedge clk);
    overrun_clr_i = 1'b0;
    ovr_exp = 1'b0;
    check("overrun_clr", 128'(overrun_o), 128'(0));
    check("valid_pulse", 128'(audio_valid_o), 128'(0));
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < int'(N_SIDS); k++) begin
      aud_val[k] = '0;
      for (int j = 0; j < 3; j++) dl[k][j] = 0;
    end
    #12;
    check("rst_stage", 128'(flt.stage_o), 128'(0));
    check("rst_sel", 128'(flt.sid_sel_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_valid", 128'(audio_valid_o), 128'(0));
    check("rst_overrun", 128'(overrun_o), 128'(0));
    check("rst_clamp", 128'(clamp_o), 128'(0));
    check("rst_audio", 128'(audio_o), 128'(0));
    check("rst_state", 128'(flt.state_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ten back-to-back fixed frames, each tick coinciding with the previous valid pulse.
    for (int f = 0; f < 10; f++) do_frame(1'b1, 1'b0, 1'b0, 1'b0);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Dropped tick mid-frame, then clear.
    do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    clear_overrun();
    // Dropped tick coinciding with clear: set wins.
    do_frame(1'b0, 1'b1, 1'b1, 1'b0);
    clear_overrun();

    // Out-of-range write-back value.
    do_frame(1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset asserted at stage 4 of instance 1.
    @(negedge clk);
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_rst_stage", 128'(flt.stage_o), 128'(4));
    check("pre_rst_sel", 128'(flt.sid_sel_o), 128'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_stage", 128'(flt.stage_o), 128'(0));
    check("midrst_busy", 128'(busy_o), 128'(0));
    check("midrst_audio", 128'(audio_o), 128'(0));
    check("midrst_clamp", 128'(clamp_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("postrst_state", 128'(flt.state_o), 128'(0));
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
